// File: rtl/md5_step_sequencer.sv
// MD5 step sequencer: walks one 512-bit block through an external single-step datapath (64 steps)
// and applies the feed-forward add. Define MD5_CHAIN_EN to add blk_first for multi-block chaining.
module md5_step_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
`ifdef MD5_CHAIN_EN
  input  logic         blk_first,
`endif
  output logic [31:0]  dp_a,
  output logic [31:0]  dp_b,
  output logic [31:0]  dp_c,
  output logic [31:0]  dp_d,
  output logic [31:0]  dp_msg,
  output logic [31:0]  dp_t,
  output logic [4:0]   dp_shift,
  output logic [1:0]   dp_func,
  input  logic [31:0]  dp_aout,
  input  logic [31:0]  dp_bout,
  input  logic [31:0]  dp_cout,
  input  logic [31:0]  dp_dout,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [127:0] digest,
  output logic         busy,
  output logic [5:0]   step
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // {H3, H2, H1, H0}
  localparam logic [127:0] IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

  localparam logic [4:0] SHIFTS [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
  };

  localparam logic [31:0] TROM [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  logic [1:0]   state_q, state_d;
  logic [5:0]   step_q, step_d;
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  a_d, b_d, c_d, d_d;
  logic [127:0] h_q, h_d;
  logic [511:0] blk_q, blk_d;
  logic [127:0] digest_q, digest_d;
  logic [127:0] h_sum;
  logic         reload_iv;
  logic         run;
  logic [1:0]   rnd;
  logic [3:0]   j;
  logic [3:0]   k;

`ifdef MD5_CHAIN_EN
  assign reload_iv = blk_first;
`else
  assign reload_iv = 1'b1;
`endif

  assign run = (state_q == RUN);
  assign rnd = step_q[5:4];
  assign j   = step_q[3:0];

  // Message word index per round, all arithmetic mod 16.
  always_comb begin
    k = j;
    case (rnd)
      2'd0:    k = j;
      2'd1:    k = (j << 2) + j + 4'd1;
      2'd2:    k = (j << 1) + j + 4'd5;
      default: k = (j << 3) - j;
    endcase
  end

  assign h_sum = {h_q[127:96] + d_q, h_q[95:64] + c_q, h_q[63:32] + b_q, h_q[31:0] + a_q};

  assign dp_a     = run ? a_q : '0;
  assign dp_b     = run ? b_q : '0;
  assign dp_c     = run ? c_q : '0;
  assign dp_d     = run ? d_q : '0;
  assign dp_msg   = run ? blk_q[{k, 5'b0} +: 32] : '0;
  assign dp_t     = run ? TROM[step_q] : '0;
  assign dp_shift = run ? SHIFTS[{rnd, step_q[1:0]}] : '0;
  assign dp_func  = run ? rnd : '0;

  assign blk_ready = (state_q == IDLE);
  assign dig_valid = (state_q == DONE);
  assign busy      = run | (state_q == FIN);
  assign digest    = digest_q;
  assign step      = step_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    h_d      = h_q;
    blk_d    = blk_q;
    digest_d = digest_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          blk_d  = blk_data;
          step_d = '0;
          if (reload_iv) begin
            h_d                  = IV;
            {d_d, c_d, b_d, a_d} = IV;
          end else begin
            {d_d, c_d, b_d, a_d} = h_q;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = dp_aout;
        b_d    = dp_bout;
        c_d    = dp_cout;
        d_d    = dp_dout;
        step_d = step_q + 6'd1;
        if (step_q == 6'd63) state_d = FIN;
      end
      FIN: begin
        h_d      = h_sum;
        digest_d = h_sum;
        state_d  = DONE;
      end
      DONE: begin
        if (dig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      h_q      <= IV;
      blk_q    <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      h_q      <= h_d;
      blk_q    <= blk_d;
      digest_q <= digest_d;
    end
  end

endmodule

// File: doc/md5_step_sequencer.md
Name: md5_step_sequencer

Overview:
- Controller that runs one 512-bit MD5 block through an external single-step round datapath, one step per clock, for 64 steps.
- Holds the A/B/C/D working registers and the chaining state H0..H3.
- Drives per-step message word, T constant, rotate amount and round-function select.
- Performs the final feed-forward add and presents the 128-bit digest on a valid/ready handshake.

Parameters:
- None. Step count (64), word width (32) and the MD5 IV are fixed by the algorithm.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low; one clock, no asynchronous reset anywhere
- blk_valid  in  1  message block offered
- blk_ready  out  1  sequencer accepts a block (high only in IDLE)
- blk_data  in  512  padded block; word k = blk_data[32k+31:32k], little-endian MD5 word order
- dp_a, dp_b, dp_c, dp_d  out  32 each  current working registers to datapath
- dp_msg  out  32  selected message word X[k]
- dp_t  out  32  constant T[i] = floor(|sin(i+1)|·2^32)
- dp_shift  out  5  rotate-left amount
- dp_func  out  2  round select: 0=F, 1=G, 2=H, 3=I
- dp_aout, dp_bout, dp_cout, dp_dout  in  32 each  datapath results (aout=d, bout=b+rot(...), cout=b, dout=c)
- dig_valid  out  1  digest available
- dig_ready  in  1  consumer accepts digest
- digest  out  128  {H3,H2,H1,H0}; H0 (A) in [31:0]
- busy  out  1  high in RUN or FIN
- step  out  6  current step index i

Behaviour:
- States: IDLE, RUN, FIN, DONE.
- Reset (rst_n=0 at a rising edge):
  - state = IDLE; step = 0; A..D = 0; H = IV (H0=0x67452301, H1=0xefcdab89, H2=0x98badcfe, H3=0x10325476).
  - Block latch cleared; dig_valid = 0; digest = 0; busy = 0.
  - blk_ready is 1 after the first clock with rst_n=1.
- Reset asserted in any state aborts the block at that edge. No partial digest is ever presented.
- IDLE:
  - blk_ready = 1.
  - On blk_valid & blk_ready: latch blk_data, load A..D from H, step = 0, go RUN.
- RUN:
  - dp_* are combinational from the registers, step and the latched block.
  - Every edge: A..D <= dp_aout..dp_dout, then step++.
  - Exactly 64 RUN cycles (step 0..63). After the step-63 edge, go FIN.
- Round r = step[5:4]; j = step[3:0]. Message index k:
  - r0: k = j
  - r1: k = (5j+1) mod 16
  - r2: k = (3j+5) mod 16
  - r3: k = 7j mod 16
- Shift = table[r][step[1:0]]:
  - r0: 7, 12, 17, 22
  - r1: 5, 9, 14, 20
  - r2: 4, 11, 16, 23
  - r3: 6, 10, 15, 21
- T ROM: 64 x 32 constant table indexed by step, T[0]=0xd76aa478, T[63]=0xeb86d391.
- FIN (1 cycle): Hn <= Hn + Xn, each add mod 2^32 with carry discarded per word. Digest register loads the new H. Go DONE.
- DONE:
  - dig_valid = 1; digest stable.
  - blk_ready = 0; a concurrent blk_valid is not accepted.
  - On dig_valid & dig_ready: go IDLE.
  - Back-to-back blocks therefore take 67 cycles minimum.
- Outside RUN, dp_a..dp_d, dp_msg, dp_t, dp_shift and dp_func are driven to 0.
- Latency: accept edge E; dig_valid high in the cycle after edge E+65.
- busy = 1 in RUN and FIN only.

Optional Feature:
- MD5_CHAIN_EN defined:
  - Adds input port blk_first (1 bit), sampled with the accepted block.
  - blk_first=1: H is reloaded with the IV before A..D are loaded.
  - blk_first=0: H from the previous block is used, for multi-block messages.
- MD5_CHAIN_EN undefined:
  - Port is absent.
  - H is reloaded with the IV on every accept, so each block is a standalone one-block message.

Test Plan:
- Empty message: block word0=0x00000080, all other words 0 -> digest H0=0xd98c1dd4, H1=0x04b2008f, H2=0x980980e9, H3=0x7e42f8ec; dig_valid 66 cycles after accept.
- "abc": word0=0x80636261, word14=0x00000018, others 0 -> H0=0x98500190, H1=0xb04fd23c, H2=0x7d3f96d6, H3=0x727fe128.
- Schedule probe:
  - step 0: dp_msg=word0, dp_shift=7, dp_t=0xd76aa478, dp_func=0
  - step 16: word1, shift 5, func 1
  - step 32: word5, shift 4, func 2
  - step 48: word0, shift 6, func 3
  - step 63: word9, shift 21, t=0xeb86d391
- Backpressure: dig_ready held 0 for 10 cycles with blk_valid=1 -> digest constant, blk_ready=0, busy=0; dig_ready=1 -> IDLE the next cycle, block accepted the cycle after.
- Mid-run reset: rst_n=0 for 1 cycle at step 30 -> IDLE, dig_valid never asserted, H=IV; rerunning the empty block gives the empty-message digest.
- MD5_CHAIN_EN: block1 = 64 bytes 'a' (first=1), block2 = padding block (first=0, word14=0x00000200) -> digest matches a software model; repeating block2 with first=1 gives a different, IV-based result.
